// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with a one-entry holding register and polled status.
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 104,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        rdata_sel,
  output logic        txd,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, hold;
  logic full, overrun, load, txd_n;
  logic hit, rd, wr, accept, last, unused;
  assign hit = mem_addr[31:3] == BASE_ADDR[31:3];
  assign rd = hit & mem_rstrb;
  assign wr = hit & ~mem_addr[2] & mem_wmask[0];
  assign last = cnt == LAST;
  // the holding slot frees up in the same cycle the shifter takes its byte
  assign accept = wr & (~full | load);
  assign busy = state != IDLE;
  assign unused = ^{mem_addr[1:0], mem_wdata[31:8], mem_wmask[3:1]};
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    load = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        load = full;
        shift_n = full ? hold : shift;
        state_n = full ? START : IDLE;
      end
      START: begin
        idx_n = last ? 3'd0 : idx;
        state_n = last ? DATA : START;
      end
      DATA: if (last) begin
        shift_n = shift >> 1;
        idx_n = idx + 1'b1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (last) begin
        load = full;
        shift_n = full ? hold : shift;
        state_n = full ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
    txd_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      hold <= '0;
      full <= 1'b0;
      overrun <= 1'b0;
      txd <= 1'b1;
      mem_rdata <= '0;
      rdata_sel <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      txd <= txd_n;
      if (accept) hold <= mem_wdata[7:0];
      full <= accept | (full & ~load);
      overrun <= (wr & ~accept) | (overrun & ~(rd & mem_addr[2]));
      rdata_sel <= rd;
      if (rd) mem_rdata <= {29'b0, overrun, full, busy};
    end
  end
endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: vector table for bus behaviour plus recorded-waveform checks of framing, back-to-back, overrun and reset.
module tb_uart_tx_io;
  localparam int CPB = 4;
  localparam logic [31:0] BASE = 32'h0040_0000;
  logic clk = 0, resetn = 0, mem_rstrb = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic [3:0] mem_wmask = 0;
  logic [31:0] mem_rdata;
  logic rdata_sel, txd, busy;
  uart_tx_io #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .rdata_sel(rdata_sel), .txd(txd), .busy(busy)
  );
  always #5 clk = ~clk;
  int nvec = 0, nerr = 0, nrec = 0;
  logic rec = 0;
  logic [127:0] wave = 0, bwave = 0;
  // one sample per cycle, taken mid-cycle, oldest sample ends up in the high bits
  always @(negedge clk) if (rec) begin
    wave = {wave[126:0], txd};
    bwave = {bwave[126:0], busy};
    nrec++;
  end
  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0] wmask;
    logic rstrb;
    logic [31:0] rdata;
    logic sel, txd, busy;
  } vec_t;
  vec_t tbl[10];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
    mem_addr = a;
    mem_wdata = d;
    mem_wmask = m;
    mem_rstrb = r;
    step;
    mem_wmask = 0;
    mem_rstrb = 0;
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic start_rec;
    wave = 0;
    bwave = 0;
    nrec = 0;
    rec = 1;
  endtask
  task automatic wait_rec(input string name, input int n);
    int g = 0;
    while (nrec < n && g < 2000) begin
      step;
      g++;
    end
    rec = 0;
    chk({name, "_len"}, nrec, n);
  endtask
  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k < CPB) return 1'b0;
    if (k < 9 * CPB) return b[(k - CPB) / CPB];
    return 1'b1;
  endfunction
  function automatic logic [127:0] exp_wave(input logic [7:0] b0, input logic [7:0] b1, input int nf, input int n, input bit bsy);
    logic [127:0] w = '0;
    for (int c = 0; c < n; c++) begin
      int f = c / (10 * CPB);
      int k = c % (10 * CPB);
      logic v;
      v = bsy ? (f < nf) : (f < nf ? fbit(f == 0 ? b0 : b1, k) : 1'b1);
      w = {w[126:0], v};
    end
    return w;
  endfunction
  initial begin
    int g;
    tbl[0] = '{BASE + 4, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{BASE + 8, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{BASE, 32'hFF, 4'b0010, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{BASE + 4, 32'h77, 4'b0001, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{BASE, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{BASE + 1, 32'hABCD0001, 4'b0001, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{BASE + 4, 32'h0, 4'b0000, 1'b1, 32'h2, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{BASE + 3, 32'h0, 4'b0000, 1'b1, 32'h1, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{BASE + 12, 32'h0, 4'b0000, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1};
    resetn = 0;
    step;
    step;
    chk("reset", {txd, busy, rdata_sel, mem_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
    resetn = 1;
    for (int i = 0; i < 10; i++) begin
      bus(tbl[i].addr, tbl[i].wdata, tbl[i].wmask, tbl[i].rstrb);
      chk($sformatf("vec%0d", i), {mem_rdata, rdata_sel, txd, busy},
          {tbl[i].rdata, tbl[i].sel, tbl[i].txd, tbl[i].busy});
    end
    g = 0;
    while (busy && g < 500) begin
      step;
      g++;
    end
    chk("drain", busy, 0);
    // single frame of 0x55; status read lands on the load edge
    bus(BASE, 32'h55, 4'b0001, 1'b0);
    chk("a_accept", {txd, busy}, 2'b10);
    bus(BASE + 4, 32'h0, 4'b0000, 1'b1);
    chk("a_status", mem_rdata, 32'h2);
    start_rec;
    wait_rec("a", 50);
    chk("a_txd", wave, exp_wave(8'h55, 8'h00, 1, 50, 0));
    chk("a_busy", bwave, exp_wave(8'h55, 8'h00, 1, 50, 1));
    // second store coincides with the first byte moving into the shifter
    bus(BASE, 32'hA3, 4'b0001, 1'b0);
    bus(BASE, 32'h0F, 4'b0001, 1'b0);
    start_rec;
    repeat (20) step;
    bus(BASE + 4, 32'h0, 4'b0000, 1'b1);
    chk("b_status", mem_rdata, 32'h3);
    wait_rec("b", 90);
    chk("b_txd", wave, exp_wave(8'hA3, 8'h0F, 2, 90, 0));
    chk("b_busy", bwave, exp_wave(8'hA3, 8'h0F, 2, 90, 1));
    // third consecutive store overruns; first STATUS read clears the sticky flag
    bus(BASE, 32'h81, 4'b0001, 1'b0);
    bus(BASE, 32'h42, 4'b0001, 1'b0);
    start_rec;
    bus(BASE, 32'hFF, 4'b0001, 1'b0);
    bus(BASE + 4, 32'h0, 4'b0000, 1'b1);
    chk("c_status1", mem_rdata, 32'h7);
    bus(BASE + 4, 32'h0, 4'b0000, 1'b1);
    chk("c_status2", mem_rdata, 32'h3);
    wait_rec("c", 100);
    chk("c_txd", wave, exp_wave(8'h81, 8'h42, 2, 100, 0));
    chk("c_busy", bwave, exp_wave(8'h81, 8'h42, 2, 100, 1));
    // reset mid-DATA with holding full and overrun set
    bus(BASE, 32'h5A, 4'b0001, 1'b0);
    bus(BASE, 32'h3C, 4'b0001, 1'b0);
    bus(BASE, 32'h99, 4'b0001, 1'b0);
    repeat (10) step;
    chk("r_pre", {busy, txd}, {1'b1, 1'b1});
    resetn = 0;
    step;
    resetn = 1;
    chk("r_reset", {txd, busy, rdata_sel, mem_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
    bus(BASE + 4, 32'h0, 4'b0000, 1'b1);
    chk("r_status", {rdata_sel, mem_rdata}, {1'b1, 32'h0});
    start_rec;
    wait_rec("r", 60);
    chk("r_txd", wave, exp_wave(8'h00, 8'h00, 0, 60, 0));
    chk("r_busy", bwave, exp_wave(8'h00, 8'h00, 0, 60, 1));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
